// File: rtl/approx_add_pipe.sv
// Two-stage elastic approximate adder (exact / LOA / truncate per transaction) with an exact
// reference path feeding saturating on-line error statistics.
module approx_add_pipe #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned APPROX_BITS = 3,
   parameter int unsigned STAT_W      = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [1:0]         in_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH:0]     out_sum,
   output logic [WIDTH:0]     out_err,
   input  logic               stat_clr,
   output logic [STAT_W-1:0]  stat_tx,
   output logic [STAT_W-1:0]  stat_errcnt,
   output logic [STAT_W-1:0]  stat_errsum
);

   localparam int unsigned SW = WIDTH + 1;
   localparam int unsigned AW = ((STAT_W > SW) ? STAT_W : SW) + 1;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic              v1_q, v2_q;
   logic [WIDTH-1:0]  a1_q, b1_q;
   logic [1:0]        mode1_q;
   logic [SW-1:0]     sum2_q, err2_q;
   logic [STAT_W-1:0] stat_tx_q, stat_errcnt_q, stat_errsum_q;

   logic          adv1, adv2, out_hs;
   logic [SW-1:0] exact_sum, loa_sum, trunc_sum, approx_sum, abs_err;

   assign adv2     = !v2_q || out_ready;
   assign adv1     = !v1_q || adv2;
   assign in_ready = adv1;
   assign out_hs   = v2_q && out_ready;

   assign exact_sum = SW'(a1_q) + SW'(b1_q);

   generate
      if (APPROX_BITS == 0) begin : g_exact
         assign loa_sum   = exact_sum;
         assign trunc_sum = exact_sum;
      end else begin : g_approx
         localparam int unsigned K = APPROX_BITS;
         logic [WIDTH-1:0] a_hi, b_hi;
         logic [K-1:0]     lo_or;
         logic             cin;
         logic [SW-1:0]    hi_trunc, hi_loa;

         assign a_hi     = a1_q >> K;
         assign b_hi     = b1_q >> K;
         assign lo_or    = a1_q[K-1:0] | b1_q[K-1:0];
         // LOA speculates the carry out of the OR-ed part from its top bit pair only
         assign cin      = a1_q[K-1] & b1_q[K-1];
         assign hi_trunc = SW'(a_hi) + SW'(b_hi);
         assign hi_loa   = hi_trunc + SW'(cin);
         assign loa_sum   = (hi_loa << K) | SW'(lo_or);
         assign trunc_sum = hi_trunc << K;
      end
   endgenerate

   always_comb begin
      approx_sum = exact_sum;
      case (mode1_q)
         2'd1:    approx_sum = loa_sum;
         2'd2:    approx_sum = trunc_sum;
         default: approx_sum = exact_sum;
      endcase
      abs_err = (exact_sum >= approx_sum) ? (exact_sum - approx_sum) : (approx_sum - exact_sum);
   end

   function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] x,
                                                 input logic [SW-1:0] y);
      logic [AW-1:0] s;
      s = AW'(x) + AW'(y);
      if (s > AW'(STAT_MAX)) return STAT_MAX;
      return s[STAT_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         a1_q    <= '0;
         b1_q    <= '0;
         mode1_q <= '0;
      end else if (adv1) begin
         v1_q <= in_valid;
         if (in_valid) begin
            a1_q    <= in_a;
            b1_q    <= in_b;
            mode1_q <= in_mode;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q   <= 1'b0;
         sum2_q <= '0;
         err2_q <= '0;
      end else if (adv2) begin
         v2_q <= v1_q;
         if (v1_q) begin
            sum2_q <= approx_sum;
            err2_q <= abs_err;
         end
      end
   end

   // Clear wins over a simultaneous handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_tx_q     <= '0;
         stat_errcnt_q <= '0;
         stat_errsum_q <= '0;
      end else if (stat_clr) begin
         stat_tx_q     <= '0;
         stat_errcnt_q <= '0;
         stat_errsum_q <= '0;
      end else if (out_hs) begin
         stat_tx_q     <= sat_add(stat_tx_q, SW'(1));
         stat_errcnt_q <= sat_add(stat_errcnt_q, SW'(err2_q != '0));
         stat_errsum_q <= sat_add(stat_errsum_q, err2_q);
      end
   end

   assign out_valid   = v2_q;
   assign out_sum     = sum2_q;
   assign out_err     = err2_q;
   assign stat_tx     = stat_tx_q;
   assign stat_errcnt = stat_errcnt_q;
   assign stat_errsum = stat_errsum_q;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Self-checking bench for approx_add_pipe: directed scenarios plus randomized backpressure
// against an arithmetic reference model; a second STAT_W=4 instance covers saturation.
module tb_approx_add_pipe;

   localparam int W = 8;
   localparam int K = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, stat_clr;
   logic [7:0]  in_a, in_b;
   logic [1:0]  in_mode;
   logic [8:0]  out_sum, out_err;
   logic [31:0] stat_tx, stat_errcnt, stat_errsum;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_stat_clr;
   logic [7:0]  s_in_a, s_in_b;
   logic [1:0]  s_in_mode;
   logic [8:0]  s_out_sum, s_out_err;
   logic [3:0]  s_stat_tx, s_stat_errcnt, s_stat_errsum;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   approx_add_pipe #(.WIDTH(W), .APPROX_BITS(K), .STAT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_err(out_err), .stat_clr(stat_clr), .stat_tx(stat_tx),
      .stat_errcnt(stat_errcnt), .stat_errsum(stat_errsum)
   );

   approx_add_pipe #(.WIDTH(W), .APPROX_BITS(K), .STAT_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a),
      .in_b(s_in_b), .in_mode(s_in_mode), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_sum(s_out_sum), .out_err(s_out_err), .stat_clr(s_stat_clr), .stat_tx(s_stat_tx),
      .stat_errcnt(s_stat_errcnt), .stat_errsum(s_stat_errsum)
   );

   // Reference arithmetic: split operands by division into high/low parts of 2**K
   function automatic int ref_sum(input int a, input int b, input int mode);
      int p;
      p = 2 ** K;
      case (mode)
         1: return ((a / p) + (b / p) + (((a / (p / 2)) % 2) & ((b / (p / 2)) % 2))) * p
                   + ((a % p) | (b % p));
         2: return ((a / p) + (b / p)) * p;
         default: return a + b;
      endcase
   endfunction

   function automatic int ref_err(input int a, input int b, input int mode);
      int s;
      s = ref_sum(a, b, mode);
      return (a + b > s) ? (a + b - s) : (s - (a + b));
   endfunction

   function automatic int imin(input int x, input int y);
      return (x < y) ? x : y;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready_during got=%b want=1", in_ready);
      else n_pass++;
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_sum !== 9'd0 || out_err !== 9'd0 || in_ready !== 1'b1)
         $display("FAIL reset_outputs got v=%b sum=%h err=%h rdy=%b want v=0 sum=0 err=0 rdy=1",
                  out_valid, out_sum, out_err, in_ready);
      else n_pass++;
      n_checks++;
      if (stat_tx !== 0 || stat_errcnt !== 0 || stat_errsum !== 0)
         $display("FAIL reset_stats got tx=%0d cnt=%0d sum=%0d want 0/0/0",
                  stat_tx, stat_errcnt, stat_errsum);
      else n_pass++;
   endtask

   task automatic test_loa();
      clear_stats();
      in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h01; in_mode = 2'd1; out_ready = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL loa_in_ready got=%b want=1", in_ready);
      else n_pass++;
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL loa_latency_early got=%b want=0", out_valid);
      else n_pass++;
      tick();
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 9'h00F || out_err !== 9'd1)
         $display("FAIL loa_result got v=%b sum=%h err=%0d want v=1 sum=00f err=1",
                  out_valid, out_sum, out_err);
      else n_pass++;
      tick();
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || stat_tx !== 1 || stat_errcnt !== 1 || stat_errsum !== 1)
         $display("FAIL loa_stats got v=%b tx=%0d cnt=%0d sum=%0d want 0 1/1/1",
                  out_valid, stat_tx, stat_errcnt, stat_errsum);
      else n_pass++;
   endtask

   task automatic test_mode_mix();
      logic [7:0] ta [4];
      logic [7:0] tb [4];
      logic [1:0] tm [4];
      logic [8:0] es [4];
      logic [8:0] ee [4];
      ta = '{8'hFF, 8'hFF, 8'hFF, 8'h0F};
      tb = '{8'hFF, 8'hFF, 8'hFF, 8'h01};
      tm = '{2'd0, 2'd1, 2'd2, 2'd2};
      // 0xFF+0xFF truncate: (31+31)<<3 = 0x1F0, |510-496| = 14
      es = '{9'h1FE, 9'h1FF, 9'h1F0, 9'h008};
      ee = '{9'd0, 9'd1, 9'd14, 9'd8};
      clear_stats();
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c < 4) begin
            in_valid = 1'b1; in_a = ta[c]; in_b = tb[c]; in_mode = tm[c];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         n_checks++;
         if (in_ready !== 1'b1) $display("FAIL mix_in_ready c=%0d got=%b want=1", c, in_ready);
         else n_pass++;
         if (c >= 2) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== es[c-2] || out_err !== ee[c-2])
               $display("FAIL mix_result idx=%0d got v=%b sum=%h err=%0d want v=1 sum=%h err=%0d",
                        c - 2, out_valid, out_sum, out_err, es[c-2], ee[c-2]);
            else n_pass++;
         end
         tick();
      end
      #1;
      n_checks++;
      if (stat_tx !== 4 || stat_errcnt !== 3 || stat_errsum !== 23)
         $display("FAIL mix_stats got tx=%0d cnt=%0d sum=%0d want 4/3/23",
                  stat_tx, stat_errcnt, stat_errsum);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int q_sum[$];
      int q_err[$];
      int sent, recvd, cyc, m_tx, m_cnt, m_sum, acc, es, ee;
      bit prev_stall;
      logic [8:0] prev_sum, prev_err;
      clear_stats();
      sent = 0; recvd = 0; cyc = 0; m_tx = 0; m_cnt = 0; m_sum = 0; prev_stall = 0;
      prev_sum = '0; prev_err = '0;
      while (recvd < 10 && cyc < 500) begin
         in_valid  = (sent < 10) && ($urandom_range(0, 3) != 0);
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         in_mode   = 2'($urandom);
         out_ready = 1'($urandom);
         #1;
         if (prev_stall) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== prev_sum || out_err !== prev_err)
               $display("FAIL bp_hold got v=%b sum=%h err=%h want v=1 sum=%h err=%h",
                        out_valid, out_sum, out_err, prev_sum, prev_err);
            else n_pass++;
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (q_sum.size() == 0) begin
               $display("FAIL bp_spurious got sum=%h want no output", out_sum);
            end else begin
               es = q_sum.pop_front();
               ee = q_err.pop_front();
               if (out_sum !== 9'(es) || out_err !== 9'(ee))
                  $display("FAIL bp_result idx=%0d got sum=%h err=%0d want sum=%h err=%0d",
                           recvd, out_sum, out_err, es, ee);
               else n_pass++;
               m_tx++; m_cnt += (ee != 0); m_sum += ee;
            end
            recvd++;
         end
         if (in_valid && in_ready) begin
            q_sum.push_back(ref_sum(int'(in_a), int'(in_b), int'(in_mode)));
            q_err.push_back(ref_err(int'(in_a), int'(in_b), int'(in_mode)));
            sent++;
         end
         prev_stall = out_valid && !out_ready;
         prev_sum = out_sum;
         prev_err = out_err;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (recvd != 10) $display("FAIL bp_timeout got=%0d want=10 results", recvd);
      else n_pass++;
      #1;
      n_checks++;
      if (stat_tx !== 32'(m_tx) || stat_errcnt !== 32'(m_cnt) || stat_errsum !== 32'(m_sum))
         $display("FAIL bp_stats got tx=%0d cnt=%0d sum=%0d want %0d/%0d/%0d",
                  stat_tx, stat_errcnt, stat_errsum, m_tx, m_cnt, m_sum);
      else n_pass++;

      // Sustained stall: the two stages fill, then in_ready must drop
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 2'($urandom);
         #1;
         if (in_ready) begin
            acc++;
            q_sum.push_back(ref_sum(int'(in_a), int'(in_b), int'(in_mode)));
            q_err.push_back(ref_err(int'(in_a), int'(in_b), int'(in_mode)));
         end
         tick();
      end
      in_valid = 1'b0;
      n_checks++;
      if (acc != 2) $display("FAIL stall_accept got=%0d want=2", acc);
      else n_pass++;
      out_ready = 1'b1;
      recvd = 0;
      for (int c = 0; c < 6 && q_sum.size() > 0; c++) begin
         #1;
         if (out_valid) begin
            es = q_sum.pop_front();
            ee = q_err.pop_front();
            n_checks++;
            if (out_sum !== 9'(es) || out_err !== 9'(ee))
               $display("FAIL stall_drain got sum=%h err=%0d want sum=%h err=%0d",
                        out_sum, out_err, es, ee);
            else n_pass++;
            recvd++;
         end
         tick();
      end
      n_checks++;
      if (recvd != 2) $display("FAIL stall_drain_count got=%0d want=2", recvd);
      else n_pass++;
   endtask

   task automatic test_saturation();
      int m_tx, m_cnt, m_sum;
      bit hs;
      s_stat_clr = 1'b1;
      tick();
      s_stat_clr = 1'b0;
      s_out_ready = 1'b1;
      m_tx = 0; m_cnt = 0; m_sum = 0;
      for (int c = 0; c < 25; c++) begin
         s_in_valid = (c < 20); s_in_a = 8'h0F; s_in_b = 8'h01; s_in_mode = 2'd2;
         #1;
         hs = s_out_valid && s_out_ready;
         if (hs) begin
            n_checks++;
            if (s_out_err !== 9'd8) $display("FAIL sat_err got=%0d want=8", s_out_err);
            else n_pass++;
         end
         tick();
         if (hs) begin
            m_tx = imin(m_tx + 1, 15); m_cnt = imin(m_cnt + 1, 15); m_sum = imin(m_sum + 8, 15);
         end
         n_checks++;
         if (s_stat_errsum !== 4'(m_sum))
            $display("FAIL sat_errsum c=%0d got=%0d want=%0d", c, s_stat_errsum, m_sum);
         else n_pass++;
      end
      s_in_valid = 1'b0;
      n_checks++;
      if (s_stat_tx !== 4'd15 || s_stat_errcnt !== 4'd15 || s_stat_errsum !== 4'd15)
         $display("FAIL sat_final got tx=%0d cnt=%0d sum=%0d want 15/15/15",
                  s_stat_tx, s_stat_errcnt, s_stat_errsum);
      else n_pass++;
   endtask

   task automatic test_clear_collision();
      clear_stats();
      out_ready = 1'b1;
      in_a = 8'h0F; in_b = 8'h01; in_mode = 2'd1;
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_err !== 9'd1)
         $display("FAIL clr_first got v=%b err=%0d want v=1 err=1", out_valid, out_err);
      else n_pass++;
      tick();
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || stat_tx !== 1)
         $display("FAIL clr_before got v=%b tx=%0d want v=1 tx=1", out_valid, stat_tx);
      else n_pass++;
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      #1;
      n_checks++;
      if (stat_tx !== 0 || stat_errcnt !== 0 || stat_errsum !== 0 || out_valid !== 1'b0)
         $display("FAIL clr_collision got tx=%0d cnt=%0d sum=%0d v=%b want 0/0/0 v=0",
                  stat_tx, stat_errcnt, stat_errsum, out_valid);
      else n_pass++;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #1;
      n_checks++;
      if (stat_tx !== 1 || stat_errcnt !== 1 || stat_errsum !== 1)
         $display("FAIL clr_after got tx=%0d cnt=%0d sum=%0d want 1/1/1",
                  stat_tx, stat_errcnt, stat_errsum);
      else n_pass++;
   endtask

   task automatic test_reset_mid_stream();
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_mode = 2'd0;
      tick();
      in_a = 8'($urandom);
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0)
         $display("FAIL rst_mid_full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_sum !== 9'd0 || out_err !== 9'd0 || in_ready !== 1'b1 ||
          stat_tx !== 0)
         $display("FAIL rst_mid_async got v=%b sum=%h err=%h rdy=%b tx=%0d want 0 0 0 1 0",
                  out_valid, out_sum, out_err, in_ready, stat_tx);
      else n_pass++;
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (out_valid !== 1'b0) $display("FAIL rst_mid_stale c=%0d got v=%b want 0", c, out_valid);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (stat_tx !== 0 || stat_errcnt !== 0 || stat_errsum !== 0)
         $display("FAIL rst_mid_stats got tx=%0d cnt=%0d sum=%0d want 0/0/0",
                  stat_tx, stat_errcnt, stat_errsum);
      else n_pass++;
   endtask

   initial begin
      in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; out_ready = 1'b0; stat_clr = 1'b0;
      s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_mode = '0; s_out_ready = 1'b0;
      s_stat_clr = 1'b0;
      test_reset();
      test_loa();
      test_mode_mix();
      test_backpressure();
      test_saturation();
      test_clear_collision();
      test_reset_mid_stream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
